// File: rtl/sync_dualrail_tx.sv
// sync_dualrail_tx: clocked-to-asynchronous bridge for a dual-rail pipeline.
// Words enter on a valid/ready port, queue in a small FIFO and leave one at a
// time as 4-phase return-to-zero dual-rail codewords. The downstream
// acknowledge is synchronized before the handshake FSM looks at it.
// Optional feature: define TX_TIMEOUT_EN to build the handshake watchdog that
// drives the sticky err flag; without it err is constant 0.
module sync_dualrail_tx #(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] dr_out,
  input  logic               ack_in,
  output logic               busy,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RTZ  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Acknowledge synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  // Shift the asynchronous acknowledge through SYNC_STAGES flops.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like real hardware.
  always_ff @(posedge clk) begin
    if (rst) ack_sync_q <= '0;
    else     ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_in};
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head;
  state_e           state_q, state_d;

  // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // A full FIFO refuses the push even if the head leaves in the same cycle.
  assign push  = in_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty && !ack_s;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Write the payload storage.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, so resetting the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  // Advance write and read pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM with registered rails
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] dr_q, dr_d;

  // Next state and next rail values; NULL is always inserted between words.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    case (state_q)
      S_IDLE: begin
        dr_d = '0;
        if (pop) begin
          for (int i = 0; i < WIDTH; i++) begin
            dr_d[2*i+1] = head[i];
            dr_d[2*i]   = ~head[i];
          end
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ack_s) begin
          dr_d    = '0;
          state_d = S_RTZ;
        end
      end
      S_RTZ: begin
        dr_d = '0;
        if (!ack_s) state_d = S_IDLE;
      end
      default: begin
        dr_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and rail registers; reset drops any word in flight to NULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
    end
  end

  assign dr_out   = dr_q;
  assign in_ready = !full;
  assign busy     = (state_q != S_IDLE) || !empty;

  // ---------------------------------------------------------------------------
  // Handshake watchdog
  // ---------------------------------------------------------------------------
`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Count cycles spent waiting on the downstream stage; flag when TIMEOUT is reached.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if ((state_d != state_q) && ((state_d == S_DATA) || (state_d == S_RTZ))) begin
      cnt_d = '0;
    end else if (((state_q == S_DATA) || (state_q == S_RTZ)) &&
                 (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(TIMEOUT)) err_d = 1'b1;
    end
  end

  // Watchdog registers; err stays set until reset, the FSM keeps waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT);
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sync_dualrail_tx.sv
// Bench for sync_dualrail_tx: a driver pushes words and queues their expected
// dual-rail codewords; a monitor pops and compares each time a new codeword
// appears, and checks the rail invariants on every change of dr_out.
module tb_sync_dualrail_tx;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int TO = 10;

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic [W-1:0]   in_data  = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dr_out;
  wire            ack_in;
  logic           busy;
  logic           err;

  int n_vec = 0;
  int n_err = 0;

  logic [2*W-1:0] exp_q [$];
  logic [2*W-1:0] prev_dr   = '0;
  bit             ack_auto  = 1'b1;
  logic           ack_force = 1'b0;
  logic           ack_emul  = 1'b0;
  int             ack_cnt   = 0;

  assign ack_in = ack_auto ? ack_emul : ack_force;

  always #5 clk = ~clk;

  sync_dualrail_tx #(
    .WIDTH      (W),
    .DEPTH      (D),
    .SYNC_STAGES(S),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dr_out   (dr_out),
    .ack_in   (ack_in),
    .busy     (busy),
    .err      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each payload bit becomes a rail pair: 1 -> 2'b10, 0 -> 2'b01.
  function automatic logic [2*W-1:0] encode(input logic [W-1:0] w);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      r = r | ((2*W)'(w[i] ? 2 : 1) << (2 * i));
    return r;
  endfunction

  // Downstream stage: follow dr_out with a 3-cycle delay in each direction.
  always @(negedge clk) begin
    if (!ack_auto) begin
      ack_emul = ack_force;
      ack_cnt  = 0;
    end else if ((dr_out != '0) != ack_emul) begin
      ack_cnt++;
      if (ack_cnt == 3) begin
        ack_emul = ~ack_emul;
        ack_cnt  = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Monitor: rail invariants on every change, scoreboard pop on each NULL->data step.
  always @(negedge clk) begin
    logic [2*W-1:0] cur;
    logic           both;
    cur = dr_out;
    if (rst) begin
      prev_dr = '0;
    end else begin
      if (cur !== prev_dr) begin
        both = 1'b0;
        for (int i = 0; i < W; i++) both = both | (cur[2*i+1] & cur[2*i]);
        check("rail_11", both, 0);
        check("data_to_data", (prev_dr != '0) && (cur != '0), 0);
        if ((prev_dr == '0) && (cur != '0)) begin
          if (exp_q.size() == 0) check("sb_underflow", cur, 0);
          else                   check("sb_word", cur, exp_q.pop_front());
        end
      end
      prev_dr = cur;
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(encode(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || exp_q.size() != 0) && t < 400);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_null"}, dr_out, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] t3_words [5];
    int           t;
    t3_words = '{4'h3, 4'hA, 4'h5, 4'hF, 4'h1};

    // T1: reset with in_valid held high must not push
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t1_dr_out", dr_out, 0);
    check("t1_in_ready", in_ready, 1);
    check("t1_busy", busy, 0);
    check("t1_err", err, 0);
    rst = 1'b0;
    exp_q.push_back(encode(4'h5));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t1_first_word", dr_out, encode(4'h5));
    check("t1_busy_active", busy, 1);
    wait_idle("t1");

    // T2: single word, full 4-phase cycle
    push_word(4'h9);
    @(posedge clk);
    @(negedge clk);
    check("t2_dr_out", dr_out, encode(4'h9));
    t = 0;
    while (dr_out != '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t2_rtz_null", dr_out, 0);
    check("t2_rtz_busy", busy, 1);
    wait_idle("t2");

    // T3: fill the FIFO with ack held low
    ack_force = 1'b0;
    ack_auto  = 1'b0;
    foreach (t3_words[i]) push_word(t3_words[i]);
    @(negedge clk);
    check("t3_full_in_ready", in_ready, 0);
    check("t3_head_out", dr_out, encode(4'h3));
    check("t3_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 4'h7;
    repeat (3) begin
      @(negedge clk);
      check("t3_still_full", in_ready, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    ack_auto = 1'b1;
    wait_idle("t3");

    // T4: reset while in DATA with ack high, then ack stays high after reset
    ack_force = 1'b0;
    ack_auto  = 1'b0;
    push_word(4'h6);
    @(posedge clk);
    @(negedge clk);
    check("t4_data", dr_out, encode(4'h6));
    ack_force = 1'b1;
    rst       = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("t4_reset_null", dr_out, 0);
    check("t4_reset_busy", busy, 0);
    rst = 1'b0;
    push_word(4'hC);
    repeat (6) begin
      @(negedge clk);
      check("t4_hold_null", dr_out, 0);
      check("t4_hold_busy", busy, 1);
    end
    ack_force = 1'b0;
    t = 0;
    while (dr_out == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t4_resume", dr_out, encode(4'hC));
    @(negedge clk);
    ack_auto = 1'b1;
    wait_idle("t4");

    // T5: handshake never acknowledged
    ack_force = 1'b0;
    ack_auto  = 1'b0;
`ifdef TX_TIMEOUT_EN
    push_word(4'h2);
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("t5_err_early", err, 0);
    @(posedge clk);
    @(negedge clk);
    check("t5_err_set", err, 1);
    check("t5_dr_held", dr_out, encode(4'h2));
    repeat (20) @(negedge clk);
    check("t5_err_hold", err, 1);
    check("t5_dr_still", dr_out, encode(4'h2));
    ack_auto = 1'b1;
    wait_idle("t5");
    check("t5_err_sticky", err, 1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("t5_err_cleared", err, 0);
`else
    push_word(4'h2);
    repeat (40) @(negedge clk);
    check("t5_no_err", err, 0);
    check("t5_dr_held", dr_out, encode(4'h2));
    ack_auto = 1'b1;
    wait_idle("t5");
    check("t5_no_err_after", err, 0);
`endif

    // T6: random traffic with random gaps
    ack_auto = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_word(W'($urandom));
    end
    wait_idle("t6");
    check("t6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
